// File: rtl/bs_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : bs_accumulator
//  Purpose  : WIDTH-bit bit-serial accumulator (LOAD/ADD/SUB/CLEAR), LSB first,
//             with start/busy/done framing, shift stall and carry/ovf/zero flags.
//             Define BS_ACCUMULATOR_SUB_EN to enable true subtraction for op 10.
//  Revision : 1.0 - initial release
// ============================================================================
module bs_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_shift,
  input  logic             i_data_in,
  output logic             o_data_out,
  output logic [WIDTH-1:0] o_value,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  localparam logic [1:0] c_OP_LOAD  = 2'b00;
  localparam logic [1:0] c_OP_ADD   = 2'b01;
  localparam logic [1:0] c_OP_SUB   = 2'b10;
  localparam logic [1:0] c_OP_CLEAR = 2'b11;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef BS_ACCUMULATOR_SUB_EN
  localparam logic c_SUB_EN = 1'b1;
`else
  localparam logic c_SUB_EN = 1'b0;
`endif

  logic [0:0]       state_q, state_d;
  logic [1:0]       op_q,    op_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic             cy_q,    cy_d;
  logic             ztrk_q,  ztrk_d;
  logic             done_q,  done_d;
  logic             fcy_q,   fcy_d;
  logic             fovf_q,  fovf_d;
  logic             fzero_q, fzero_d;

  logic w_run;
  logic w_step;
  logic w_last;
  logic w_is_sub;
  logic w_is_arith;
  logic w_opnd;
  logic w_sum;
  logic w_cout;
  logic w_r;

  assign w_run      = (state_q == c_ST_RUN);
  assign w_step     = w_run & i_shift;
  assign w_last     = (cnt_q == c_CNT_LAST);
  assign w_is_sub   = c_SUB_EN & (op_q == c_OP_SUB);
  assign w_is_arith = (op_q == c_OP_ADD) | (op_q == c_OP_SUB);

  // Subtraction is addition of the inverted operand with a carry preset of 1.
  assign w_opnd = i_data_in ^ w_is_sub;
  assign w_sum  = word_q[0] ^ w_opnd ^ cy_q;
  assign w_cout = (word_q[0] & w_opnd) | (word_q[0] & cy_q) | (w_opnd & cy_q);

  always_comb begin
    w_r = 1'b0;
    case (op_q)
      c_OP_LOAD:  w_r = i_data_in;
      c_OP_ADD:   w_r = w_sum;
      c_OP_SUB:   w_r = w_sum;
      c_OP_CLEAR: w_r = 1'b0;
      default:    w_r = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    cy_d    = cy_q;
    ztrk_d  = ztrk_q;
    done_d  = 1'b0;
    fcy_d   = fcy_q;
    fovf_d  = fovf_q;
    fzero_d = fzero_q;

    if (state_q == c_ST_IDLE) begin
      if (i_start) begin
        state_d = c_ST_RUN;
        op_d    = i_op;
        cnt_d   = '0;
        cy_d    = c_SUB_EN & (i_op == c_OP_SUB);
        ztrk_d  = 1'b1;
      end
    end else if (w_step) begin
      word_d = {w_r, word_q[WIDTH-1:1]};
      cy_d   = w_is_arith ? w_cout : cy_q;
      ztrk_d = ztrk_q & ~w_r;
      cnt_d  = cnt_q + CNT_W'(1);
      if (w_last) begin
        // cy_q is the carry into the MSB on the final step.
        state_d = c_ST_IDLE;
        done_d  = 1'b1;
        fcy_d   = w_is_arith & w_cout;
        fovf_d  = w_is_arith & (cy_q ^ w_cout);
        fzero_d = ztrk_q & ~w_r;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= c_ST_IDLE;
      op_q    <= c_OP_LOAD;
      cnt_q   <= '0;
      word_q  <= '0;
      cy_q    <= 1'b0;
      ztrk_q  <= 1'b1;
      done_q  <= 1'b0;
      fcy_q   <= 1'b0;
      fovf_q  <= 1'b0;
      fzero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      cy_q    <= cy_d;
      ztrk_q  <= ztrk_d;
      done_q  <= done_d;
      fcy_q   <= fcy_d;
      fovf_q  <= fovf_d;
      fzero_q <= fzero_d;
    end
  end

  assign o_data_out = word_q[0];
  assign o_value    = word_q;
  assign o_busy     = w_run;
  assign o_done     = done_q;
  assign o_carry    = fcy_q;
  assign o_ovf      = fovf_q;
  assign o_zero     = fzero_q;

endmodule
`default_nettype wire

// File: tb/tb_bs_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bs_accumulator
//  Purpose  : Self-checking bench for bs_accumulator (WIDTH=8) against a
//             word-level arithmetic model plus directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bs_accumulator;

  localparam int W = 8;

`ifdef BS_ACCUMULATOR_SUB_EN
  localparam bit c_SUB_EN = 1'b1;
`else
  localparam bit c_SUB_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op_in;
  logic         shift;
  logic         data_in;
  logic         data_out;
  logic [W-1:0] value;
  logic         busy;
  logic         done;
  logic         carry;
  logic         ovf;
  logic         zero;

  int n_checks = 0;
  int n_pass   = 0;

  bs_accumulator #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_op      (op_in),
    .i_shift   (shift),
    .i_data_in (data_in),
    .o_data_out(data_out),
    .o_value   (value),
    .o_busy    (busy),
    .o_done    (done),
    .o_carry   (carry),
    .o_ovf     (ovf),
    .o_zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Word-level result of an operation on 8-bit values.
  function automatic logic [7:0] f_res(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   f_res = b;
      2'b01:   f_res = a + b;
      2'b10:   f_res = c_SUB_EN ? (a - b) : (a + b);
      default: f_res = 8'h00;
    endcase
  endfunction

  function automatic bit f_carry(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    if (op == 2'b01 || (op == 2'b10 && !c_SUB_EN)) begin
      s = int'(a) + int'(b);
      f_carry = (s > 255);
    end else if (op == 2'b10) f_carry = (a >= b);
    else f_carry = 1'b0;
  endfunction

  function automatic bit f_ovf(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == 2'b01 || (op == 2'b10 && !c_SUB_EN)) s = sa + sb;
    else if (op == 2'b10) s = sa - sb;
    else s = 0;
    f_ovf = (s > 127) || (s < -128);
  endfunction

  // Model state
  bit         m_init = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  bit         m_carry = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_zero = 1'b1;
  logic [7:0] m_val = 8'h00;
  logic [7:0] m_old = 8'h00;
  logic [7:0] m_opd = 8'h00;
  logic [1:0] m_op = 2'b00;
  int         m_k = 0;

  always @(posedge clk) begin
    m_init = 1'b1;
    if (rst) begin
      m_busy = 0; m_done = 0; m_carry = 0; m_ovf = 0; m_zero = 1;
      m_val = 8'h00; m_k = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_op = op_in; m_k = 0; m_opd = 8'h00; m_old = m_val;
        end
      end else if (shift) begin
        m_opd[m_k] = data_in;
        m_k++;
        if (m_k == W) begin
          m_val   = f_res(m_op, m_old, m_opd);
          m_carry = f_carry(m_op, m_old, m_opd);
          m_ovf   = f_ovf(m_op, m_old, m_opd);
          m_zero  = (m_val == 8'h00);
          m_done  = 1;
          m_busy  = 0;
        end
      end
    end
  end

  // Mid-run register: remaining old bits below, low k result bits on top.
  always @(negedge clk) begin
    logic [15:0] mask, partial;
    if (m_init) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("carry", carry, m_carry);
      check("ovf", ovf, m_ovf);
      check("zero", zero, m_zero);
      if (m_busy) begin
        mask    = (16'h1 << m_k) - 16'h1;
        partial = (16'(m_old) >> m_k) |
                  ((16'(f_res(m_op, m_old, m_opd)) & mask) << (W - m_k));
        check("value_run", value, partial[7:0]);
        check("dout_run", data_out, m_old[m_k]);
      end else begin
        check("value", value, m_val);
        check("dout", data_out, m_val[0]);
      end
    end
  end

  // Drive start for one cycle; call at posedge+1.
  task automatic launch(input logic [1:0] op);
    start = 1'b1;
    op_in = op;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Stream an operand. mode 1: shift toggles 0,1,... from the first RUN cycle.
  task automatic stream(input logic [7:0] opd, input int mode, input bit chain,
                        input logic [1:0] chain_op, input bit mid_start, input int abort_at,
                        output int lat, output int busy_cyc, output logic [7:0] streamed);
    int  k;
    int  cyc;
    bit  aborted;
    k = 0; cyc = 0; lat = 1; busy_cyc = 0; streamed = 8'h00; aborted = 0;
    while (k < W && cyc < 100 && !aborted) begin
      if (k == abort_at) begin
        rst = 1'b1;
        shift = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_value", value, 8'h00);
        check("abort_zero", zero, 1'b1);
        check("abort_carry", carry, 1'b0);
        aborted = 1;
      end else begin
        shift   = (mode == 1) ? cyc[0] : 1'b1;
        data_in = opd[k];
        if (mid_start && cyc == 3) begin
          start = 1'b1;
          op_in = 2'b01;
        end
        if (shift) streamed[k] = data_out;
        busy_cyc += int'(busy);
        @(posedge clk);
        lat++;
        if (shift) k++;
        cyc++;
        #1 start = 1'b0;
      end
    end
    if (!aborted) begin
      if (cyc >= 100) check("timeout", 1'b0, 1'b1);
      check("done_pulse", done, 1'b1);
      check("busy_at_done", busy, 1'b0);
      if (chain) begin
        start = 1'b1;
        op_in = chain_op;
        @(posedge clk);
        #1 start = 1'b0;
        check("chain_busy", busy, 1'b1);
      end else shift = 1'b0;
    end
  endtask

  initial begin
    int         lat, bc;
    logic [7:0] so;
    rst = 1'b1; start = 1'b0; op_in = 2'b00; shift = 1'b0; data_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_value", value, 8'h00);
    check("rst_zero", zero, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_dout", data_out, 1'b0);

    // LOAD 0xA5
    launch(2'b00);
    stream(8'hA5, 0, 0, 2'b00, 0, -1, lat, bc, so);
    check("load_lat", lat, 9);
    check("load_value", value, 8'hA5);
    check("load_zero", zero, 1'b0);
    check("load_carry", carry, 1'b0);
    check("load_ovf", ovf, 1'b0);
    check("load_stream", so, 8'h00);

    // LOAD 0x7F, ADD 0x01
    launch(2'b00);
    stream(8'h7F, 0, 0, 2'b00, 0, -1, lat, bc, so);
    launch(2'b01);
    stream(8'h01, 0, 0, 2'b00, 0, -1, lat, bc, so);
    check("add_value", value, 8'h80);
    check("add_ovf", ovf, 1'b1);
    check("add_carry", carry, 1'b0);
    check("add_stream", so, 8'h7F);

    // LOAD 0x05, SUB 0x05
    launch(2'b00);
    stream(8'h05, 0, 0, 2'b00, 0, -1, lat, bc, so);
    launch(2'b10);
    stream(8'h05, 0, 0, 2'b00, 0, -1, lat, bc, so);
`ifdef BS_ACCUMULATOR_SUB_EN
    check("sub_value", value, 8'h00);
    check("sub_zero", zero, 1'b1);
    check("sub_carry", carry, 1'b1);
    check("sub_ovf", ovf, 1'b0);
`else
    check("sub_value", value, 8'h0A);
    check("sub_zero", zero, 1'b0);
    check("sub_carry", carry, 1'b0);
`endif

    // LOAD 0x10, ADD 0x03 with stalls
    launch(2'b00);
    stream(8'h10, 0, 0, 2'b00, 0, -1, lat, bc, so);
    launch(2'b01);
    stream(8'h03, 1, 0, 2'b00, 0, -1, lat, bc, so);
    check("stall_busy_cycles", bc, 16);
    check("stall_value", value, 8'h13);

    // ADD aborted by reset after 4 steps, then LOAD 0x3C
    launch(2'b01);
    stream(8'h22, 0, 0, 2'b00, 0, 4, lat, bc, so);
    launch(2'b00);
    stream(8'h3C, 0, 0, 2'b00, 0, -1, lat, bc, so);
    check("post_rst_value", value, 8'h3C);

    // LOAD 0xFF chained into CLEAR, with an ignored mid-run start
    launch(2'b00);
    stream(8'hFF, 0, 1, 2'b11, 0, -1, lat, bc, so);
    stream(8'h5A, 0, 0, 2'b00, 1, -1, lat, bc, so);
    check("clear_value", value, 8'h00);
    check("clear_zero", zero, 1'b1);
    check("clear_stream", so, 8'hFF);
    @(posedge clk);
    #1 check("no_requeue", busy, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
